// File: rtl/reg_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reg_bus_pkg
// Purpose : Shared constants and helpers for the reg_bus_bank slice.
//           Provides the default bank geometry, the width of a register
//           index, and the saturation limit of the conflict counter.
// Ports   : none (package)
// Macro   : REG_BUS_BYPASS_EN (used by reg_bus_bank, not by this package)
// Revision: 1.0 - initial release
// ============================================================================
package reg_bus_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREG  = 4;
  localparam int DEF_CNT_W = 8;

  // Width of a register index. This is never smaller than 1, so a
  // degenerate bank still gets a legal vector.
  function automatic int src_w(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  localparam int DEF_SRC_W = src_w(DEF_NREG);

  // All-ones value of a CNT_W-bit counter (saturation point)
  localparam logic [DEF_CNT_W-1:0] DEF_CNT_MAX = {DEF_CNT_W{1'b1}};

endpackage : reg_bus_pkg
`default_nettype wire

// File: rtl/reg_bus_bank_prio_enc.sv
`default_nettype none
// ============================================================================
// Module  : prio_enc
// Purpose : Combinational lowest-index-first priority encoder.
// Ports   : i_req   [NREG-1:0]  request vector
//           o_idx   [SRC_W-1:0] index of lowest set request (0 if none)
//           o_any               at least one request set
//           o_multi             two or more requests set
// Macro   : none
// Revision: 1.0 - initial release
// ============================================================================
module prio_enc #(
  parameter int NREG  = 4,
  parameter int SRC_W = 2
) (
  input  logic [NREG-1:0]  i_req,
  output logic [SRC_W-1:0] o_idx,
  output logic             o_any,
  output logic             o_multi
);

  // Scan from the top down so the lowest set index is the last to write
  always_comb begin
    o_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = SRC_W'(i);
    end
  end

  assign o_any   = |i_req;
  // Clearing the lowest set bit leaves something only if two or more were set
  assign o_multi = |(i_req & (i_req - NREG'(1)));

endmodule : prio_enc
`default_nettype wire

// File: rtl/reg_bus_bank.sv
`default_nettype none
// ============================================================================
// Module  : reg_bus_bank
// Purpose : Bank of NREG WIDTH-bit registers that share one registered read
//           bus. A fixed-priority arbiter picks the lowest requesting index.
//           Contention is flagged and counted with saturation.
// Ports   : clk, rst_n (async, active low)
//           in_data  [WIDTH-1:0]  broadcast write data
//           set      [NREG-1:0]   per-register load strobes
//           en       [NREG-1:0]   per-register bus requests
//           clr_cnt               synchronous clear of conflict_cnt
//           out_data [WIDTH-1:0]  registered bus value (holds when idle)
//           out_valid             a register drove out_data last cycle
//           out_src  [SRC_W-1:0]  index of the driving register
//           conflict              more than one request last cycle
//           conflict_cnt[CNT_W-1:0] saturating conflict count
// Macro   : REG_BUS_BYPASS_EN - when defined, a same-cycle write to the
//           winning register is forwarded onto the bus.
// Revision: 1.0 - initial release
// ============================================================================
module reg_bus_bank
  import reg_bus_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [NREG-1:0]          set,
  input  logic [NREG-1:0]          en,
  input  logic                     clr_cnt,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  output logic [src_w(NREG)-1:0]   out_src,
  output logic                     conflict,
  output logic [CNT_W-1:0]         conflict_cnt
);

  localparam int               SRC_W   = src_w(NREG);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] r_regs [NREG];
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SRC_W-1:0] r_out_src;
  logic             r_conflict;
  logic [CNT_W-1:0] r_cnt;

  logic [SRC_W-1:0] w_idx;
  logic             w_any;
  logic             w_multi;
  logic [WIDTH-1:0] w_rd_data;

  prio_enc #(
    .NREG  (NREG),
    .SRC_W (SRC_W)
  ) u_prio_enc (
    .i_req   (en),
    .o_idx   (w_idx),
    .o_any   (w_any),
    .o_multi (w_multi)
  );

  // Value placed on the bus for the current winner
  always_comb begin
    w_rd_data = r_regs[w_idx];
`ifdef REG_BUS_BYPASS_EN
    if (set[w_idx]) w_rd_data = in_data;
`endif
  end

  // Register array: broadcast load, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (set[i]) r_regs[i] <= in_data;
      end
    end
  end

  // Output stage: data/source hold when nothing is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_src   <= '0;
      r_conflict  <= 1'b0;
    end else begin
      r_out_valid <= w_any;
      r_conflict  <= w_multi;
      if (w_any) begin
        r_out_data <= w_rd_data;
        r_out_src  <= w_idx;
      end
    end
  end

  // Conflict counter: clear has priority over increment, saturates at max
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_cnt) begin
      r_cnt <= '0;
    end else if (w_multi && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign out_src      = r_out_src;
  assign conflict     = r_conflict;
  assign conflict_cnt = r_cnt;

endmodule : reg_bus_bank
`default_nettype wire

// File: tb/tb_reg_bus_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_bus_bank
// Purpose : Self-checking bench for reg_bus_bank (default geometry
//           WIDTH=16, NREG=4, CNT_W=8). A behavioural model tracks the
//           expected outputs and is compared every cycle, and directed
//           vectors carry hand-computed literal expectations.
// Macro   : REG_BUS_BYPASS_EN changes the same-cycle write/read expectation
// Revision: 1.0 - initial release
// ============================================================================
module tb_reg_bus_bank;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic [3:0]  set;
  logic [3:0]  en;
  logic        clr_cnt;
  logic [15:0] out_data;
  logic        out_valid;
  logic [1:0]  out_src;
  logic        conflict;
  logic [7:0]  conflict_cnt;

  int n_pass;
  int n_total;

  reg_bus_bank dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .set          (set),
    .en           (en),
    .clr_cnt      (clr_cnt),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_src      (out_src),
    .conflict     (conflict),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int  m_reg [4];
  int  m_data, m_src, m_valid, m_conf, m_cnt;
  bit  byp;

  initial begin
`ifdef REG_BUS_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_reg[i]) m_reg[i] = 0;
      m_data = 0; m_src = 0; m_valid = 0; m_conf = 0; m_cnt = 0;
    end else begin
      int g;
      g = -1;
      for (int i = 0; i < 4; i++) if (en[i] && g < 0) g = i;
      if (g >= 0) begin
        m_data  = (byp && set[g]) ? int'(in_data) : m_reg[g];
        m_src   = g;
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
      m_conf = ($countones(en) >= 2) ? 1 : 0;
      if (clr_cnt) m_cnt = 0;
      else if (m_conf == 1 && m_cnt < 255) m_cnt = m_cnt + 1;
      for (int i = 0; i < 4; i++) if (set[i]) m_reg[i] = int'(in_data);
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    check("model_data",  int'(out_data),     m_data);
    check("model_valid", int'(out_valid),    m_valid);
    check("model_src",   int'(out_src),      m_src);
    check("model_conf",  int'(conflict),     m_conf);
    check("model_cnt",   int'(conflict_cnt), m_cnt);
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; in_data = '0; set = '0; en = '0; clr_cnt = 1'b0;
    #12;
    check("rst_data",  int'(out_data), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_cnt",   int'(conflict_cnt), 0);
    #2 rst_n = 1'b1;  // released mid-cycle, away from both edges
    step();
    check("idle_valid", int'(out_valid), 0);

    // All registers read back zero
    for (int i = 0; i < 4; i++) begin
      en = 4'(1 << i);
      step();
      check("rd0_data",  int'(out_data), 0);
      check("rd0_src",   int'(out_src), i);
      check("rd0_valid", int'(out_valid), 1);
    end
    en = '0;

    // Single load and read
    in_data = 16'hABCD; set = 4'b0001; step();
    set = '0; en = 4'b0001; step();
    check("ld_data",  int'(out_data), 16'hABCD);
    check("ld_src",   int'(out_src), 0);
    check("ld_valid", int'(out_valid), 1);
    en = '0; step();
    check("hold_valid", int'(out_valid), 0);
    check("hold_data",  int'(out_data), 16'hABCD);

    // Broadcast and contention
    in_data = 16'hCCCC; set = 4'b0110; step();
    set = '0; en = 4'b0110; step();
    check("bc_data", int'(out_data), 16'hCCCC);
    check("bc_src",  int'(out_src), 1);
    check("bc_conf", int'(conflict), 1);
    check("bc_cnt",  int'(conflict_cnt), 1);
    en = '0; step();
    check("bc_conf_off", int'(conflict), 0);
    check("bc_cnt_hold", int'(conflict_cnt), 1);
    en = 4'b0110;
    for (int k = 0; k < 300; k++) step();
    check("sat_cnt", int'(conflict_cnt), 255);
    clr_cnt = 1'b1; step();
    check("clr_cnt",  int'(conflict_cnt), 0);
    check("clr_conf", int'(conflict), 1);
    clr_cnt = 1'b0; en = '0; step();

    // Same-cycle write and read of reg0 (holds ABCD)
    in_data = 16'hAAAA; set = 4'b0001; en = 4'b0001; step();
    check("wr_rd_data", int'(out_data), byp ? 16'hAAAA : 16'hABCD);
    set = '0; step();
    check("wr_rd_next", int'(out_data), 16'hAAAA);
    en = '0;

    // Distinct values then back-to-back grants
    for (int i = 0; i < 4; i++) begin
      in_data = 16'((i + 1) * 16'h1111); set = 4'(1 << i); step();
    end
    set = '0;
    for (int i = 0; i < 4; i++) begin
      en = 4'(1 << i); step();
      check("b2b_src",   int'(out_src), i);
      check("b2b_valid", int'(out_valid), 1);
      check("b2b_data",  int'(out_data), (i + 1) * 16'h1111);
    end
    en = '0; step();

    // Reset mid-operation
    in_data = 16'h5555; set = 4'b1111; en = 4'b1000;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    check("mid_rst_data",  int'(out_data), 0);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_src",   int'(out_src), 0);
    check("mid_rst_conf",  int'(conflict), 0);
    check("mid_rst_cnt",   int'(conflict_cnt), 0);
    set = '0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    step();
    check("post_rst_data",  int'(out_data), 0);
    check("post_rst_src",   int'(out_src), 3);
    check("post_rst_valid", int'(out_valid), 1);
    en = '0; step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_reg_bus_bank
`default_nettype wire

// File: doc/reg_bus_bank.md
# reg_bus_bank

Parametrised bank of NREG clocked WIDTH-bit registers that share one output bus. Every register has its own load strobe and bus request. The bus is resolved by a fixed-priority arbiter into a registered output, not by tristate drivers, so contention can no longer corrupt the bus. Contention is flagged and counted. The block sits between the datapath write bus and any consumer of a shared register-read bus, and it replaces ad-hoc wiring of several single registers onto one net.

## Interface
- WIDTH, 16, data width of each register and of the bus
- NREG, 4, number of registers; legal range 2..16
- CNT_W, 8, width of the conflict counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  WIDTH  shared write data
- set  in  NREG  per-register load strobe; bit i loads register i
- en  in  NREG  per-register bus request; bit i asks to drive register i onto the bus
- clr_cnt  in  1  synchronous clear of conflict_cnt
- out_data  out  WIDTH  registered bus value
- out_valid  out  1  out_data was driven by a register in the previous cycle
- out_src  out  $clog2(NREG)  index of the register that drove out_data
- conflict  out  1  one-cycle pulse: more than one en bit was set in the previous cycle
- conflict_cnt  out  CNT_W  saturating count of conflicting cycles

## Operation
- **Loads.** Register i takes in_data on a clock edge when set[i]=1. Several set bits may be high in the same cycle; all of those registers load the same value (broadcast). A register with set[i]=0 holds its value.
- **Arbitration.** The grant goes to the lowest index i with en[i]=1. The arbiter is combinational within the cycle and its result is registered at the clock edge.
- **With a grant:**
  - out_data = register i
  - out_src = i
  - out_valid = 1
- **Without a grant** (en all zero):
  - out_data and out_src hold their last values
  - out_valid = 0
  - The bus never floats and never shows X.
- **Read value without the bypass feature:** the value register i held before the same edge's load.
- **Contention.** When popcount(en) ≥ 2:
  - conflict = 1 for the next cycle
  - the winner is still the lowest index
  - conflict_cnt increments by 1
  - conflict_cnt saturates at 2^CNT_W−1 and does not wrap
- **clr_cnt.** Sets conflict_cnt to 0 at the next edge. If clr_cnt and a conflict occur in the same cycle, clr_cnt wins and the count becomes 0. The conflict pulse still asserts.
- **Reset (rst_n low), asynchronously:**
  - all registers = 0
  - out_data = 0
  - out_valid = 0
  - out_src = 0
  - conflict = 0
  - conflict_cnt = 0
- **Reset mid-operation.** Asserting reset mid-operation discards any pending load or grant. The first edge after rst_n rises behaves like a normal cycle.

## Timing
- Load latency: 1 cycle. The register updates at the edge where set is sampled.
- Read latency: 1 cycle from en to out_data, out_valid and out_src.
- conflict and conflict_cnt update at the same edge as the corresponding out_data.
- Back-to-back grants to different registers are allowed every cycle, with no dead cycle.
- Same-cycle load and read of the same register: out_data shows the old value. Exception: when the bypass feature is compiled in, see Configuration.

## Configuration
- Macro: REG_BUS_BYPASS_EN.
- **Defined:** if the winning index i also has set[i]=1 in the same cycle, out_data = in_data. The read sees the value being written, so read latency through a write is 1 cycle.
- **Undefined:** out_data is the pre-write register value. The newly written value is visible from the next read onward.
- All other behaviour is identical in both builds.

## Structure
- **Package reg_bus_pkg:**
  - default WIDTH, NREG and CNT_W constants
  - an SRC_W function/localparam computing $clog2(NREG)
  - the saturation max constant for the counter
- **Sub-module prio_enc:**
  - parametrised NREG-input lowest-index-first priority encoder
  - outputs: index, any-valid, multi-hot (popcount ≥ 2)
  - purely combinational, instantiated once
- **Top module:** register array, output registers and counter.

## Test plan
- **Reset and idle:** hold rst_n=0, then release with en=0. Expect:
  - out_data=0, out_valid=0, conflict_cnt=0
  - all registers read back 0 via single en pulses
- **Single load and read:** in_data=16'hABCD, set=4'b0001 for one cycle, then en=4'b0001. Expect:
  - the next cycle shows out_data=ABCD, out_src=0, out_valid=1
  - after en drops, out_valid=0 and out_data holds ABCD
- **Broadcast and contention:**
  - set=4'b0110 with in_data=CCCC, then en=4'b0110
  - expect out_data=CCCC, out_src=1, conflict pulse=1, conflict_cnt=1
  - repeat 300 cycles at CNT_W=8: conflict_cnt saturates at 255
  - then clr_cnt together with a conflict gives conflict_cnt=0
- **Same-cycle write and read:** reg0=ABCD; apply in_data=AAAA, set=4'b0001, en=4'b0001. Expect:
  - out_data=ABCD without REG_BUS_BYPASS_EN
  - out_data=AAAA with it
  - the following read returns AAAA in both builds
- **Reset mid-operation:** assert rst_n during set=4'b1111 and en=4'b1000. Expect:
  - all outputs 0 immediately
  - reg3 reads 0 after release
- **Back-to-back grants:** en sequence 0001, 0010, 0100, 1000 on consecutive cycles with distinct stored values. Expect:
  - out_src=0,1,2,3 on consecutive cycles
  - out_valid stays high and there are no gaps
